// File: rtl/result_uart_streamer_if.sv
// Read-port and UART-side signals of the result streamer.
// master is the streamer itself; slave is the RAM/host side.
interface result_uart_streamer_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 8
);
  logic                 start;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] ram_q;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    input  start,
    input  ram_q,
    output rd_addr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output ram_q,
    input  rd_addr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/result_uart_streamer.sv
// Streams filter-output RAM words 0..LEN-1 onto a UART 8N1 line after a start pulse.
// The RAM read port has RD_LATENCY cycles of latency; each fetch waits it out with tx idle high.
module result_uart_streamer #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned LEN          = 255,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  result_uart_streamer_if.master bus
);

  localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAT_CNT   = (RD_LATENCY > 0) ? RD_LATENCY : 1;
  localparam int unsigned LAT_W     = (LAT_CNT > 1) ? $clog2(LAT_CNT) : 1;
  localparam int unsigned BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned LAST_WORD = (LEN > 0) ? LEN - 1 : 0;

  localparam logic [BAUD_W-1:0]    BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LAT_W-1:0]     LAT_MAX   = LAT_W'(LAT_CNT - 1);
  localparam logic [BIT_W-1:0]     BIT_MAX   = BIT_W'(DATA_BITS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(LAST_WORD);
  localparam logic                 LEN_ZERO  = (LEN == 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [ADDR_BITS-1:0]   addr_nxt;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_nxt;
  logic [BAUD_W-1:0]      baud_q;
  logic [BAUD_W-1:0]      baud_nxt;
  logic [BIT_W-1:0]       bit_q;
  logic [BIT_W-1:0]       bit_nxt;
  logic [LAT_W-1:0]       lat_q;
  logic [LAT_W-1:0]       lat_nxt;
  logic                   tx_q;
  logic                   tx_nxt;
  logic                   busy_q;
  logic                   busy_nxt;
  logic                   done_q;
  logic                   done_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      shift_q <= shift_nxt;
      baud_q  <= baud_nxt;
      bit_q   <= bit_nxt;
      lat_q   <= lat_nxt;
      tx_q    <= tx_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    shift_nxt = shift_q;
    baud_nxt  = '0;
    bit_nxt   = bit_q;
    lat_nxt   = '0;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          addr_nxt = '0;
          if (LEN_ZERO) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_FETCH;
            busy_nxt  = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (lat_q == LAT_MAX) begin
          shift_nxt = bus.ram_q;
          state_nxt = ST_START;
        end else begin
          lat_nxt = lat_q + 1'b1;
        end
      end

      ST_START: begin
        if (baud_q == BAUD_MAX) begin
          bit_nxt   = '0;
          state_nxt = ST_DATA;
        end else begin
          baud_nxt = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_q == BAUD_MAX) begin
          shift_nxt = shift_q >> 1;
          if (bit_q == BIT_MAX) begin
            state_nxt = ST_STOP;
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end else begin
          baud_nxt = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_q == BAUD_MAX) begin
          if (addr_q == LAST_ADDR) begin
            state_nxt = ST_DONE;
          end else begin
            addr_nxt  = addr_q + 1'b1;
            state_nxt = ST_FETCH;
          end
        end else begin
          baud_nxt = baud_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // DONE entry ends the dump: release busy and park the address at 0
    if (state_nxt == ST_DONE) begin
      busy_nxt = 1'b0;
      addr_nxt = '0;
      done_nxt = 1'b1;
    end

    // tx follows the state being entered so the line register never lags the FSM
    if (state_nxt == ST_START) begin
      tx_nxt = 1'b0;
    end else if (state_nxt == ST_DATA) begin
      tx_nxt = shift_nxt[0];
    end
  end

  assign bus.rd_addr = addr_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_result_uart_streamer.sv
// Directed bench for result_uart_streamer: four parameterisations, one selected at a time,
// each dump captured cycle by cycle and compared against frames built from the RAM contents.
module tb_result_uart_streamer;

  localparam int unsigned TR_MAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  logic start_drv = 1'b0;
  logic rst_drv   = 1'b0;
  logic rst_a, rst_b, rst_c, rst_d;

  logic [7:0] mem [256];

  logic       m_tx, m_busy, m_done;
  logic [7:0] m_addr;

  logic       tr_tx   [TR_MAX];
  logic       tr_busy [TR_MAX];
  logic       tr_done [TR_MAX];
  logic [7:0] tr_addr [TR_MAX];

  result_uart_streamer_if #(.DATA_BITS(8), .ADDR_BITS(8)) if_a ();
  result_uart_streamer_if #(.DATA_BITS(8), .ADDR_BITS(8)) if_b ();
  result_uart_streamer_if #(.DATA_BITS(8), .ADDR_BITS(8)) if_c ();
  result_uart_streamer_if #(.DATA_BITS(8), .ADDR_BITS(8)) if_d ();

  result_uart_streamer #(.DATA_BITS(8), .ADDR_BITS(8), .LEN(3), .CLKS_PER_BIT(4), .RD_LATENCY(2))
    u_a (.clk(clk), .rst(rst_a), .bus(if_a));
  result_uart_streamer #(.DATA_BITS(8), .ADDR_BITS(8), .LEN(2), .CLKS_PER_BIT(4), .RD_LATENCY(2))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b));
  result_uart_streamer #(.DATA_BITS(8), .ADDR_BITS(8), .LEN(256), .CLKS_PER_BIT(1), .RD_LATENCY(2))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c));
  result_uart_streamer #(.DATA_BITS(8), .ADDR_BITS(8), .LEN(0), .CLKS_PER_BIT(4), .RD_LATENCY(2))
    u_d (.clk(clk), .rst(rst_d), .bus(if_d));

  // Unselected instances are held in reset
  assign rst_a = (sel == 0) ? rst_drv : 1'b0;
  assign rst_b = (sel == 1) ? rst_drv : 1'b0;
  assign rst_c = (sel == 2) ? rst_drv : 1'b0;
  assign rst_d = (sel == 3) ? rst_drv : 1'b0;

  assign if_a.start = start_drv && (sel == 0);
  assign if_b.start = start_drv && (sel == 1);
  assign if_c.start = start_drv && (sel == 2);
  assign if_d.start = start_drv && (sel == 3);

  // RAM output register; the DUT's rd_addr register supplies the other latency stage
  always_ff @(posedge clk) begin
    if_a.ram_q <= mem[if_a.rd_addr];
    if_b.ram_q <= mem[if_b.rd_addr];
    if_c.ram_q <= mem[if_c.rd_addr];
    if_d.ram_q <= mem[if_d.rd_addr];
  end

  always_comb begin
    case (sel)
      0:       begin m_tx = if_a.tx; m_busy = if_a.busy; m_done = if_a.done; m_addr = if_a.rd_addr; end
      1:       begin m_tx = if_b.tx; m_busy = if_b.busy; m_done = if_b.done; m_addr = if_b.rd_addr; end
      2:       begin m_tx = if_c.tx; m_busy = if_c.busy; m_done = if_c.done; m_addr = if_c.rd_addr; end
      default: begin m_tx = if_d.tx; m_busy = if_d.busy; m_done = if_d.done; m_addr = if_d.rd_addr; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pick an instance and give it a clean reset; returns at a negedge with rst released
  task automatic select_dut(input int k);
    start_drv = 1'b0;
    sel       = k;
    rst_drv   = 1'b0;
    repeat (3) @(negedge clk);
    rst_drv = 1'b1;
    @(negedge clk);
  endtask

  // Raise start at the current negedge; sample i is taken i cycles after start was accepted
  task automatic run_dump(input int n, input bit hold);
    start_drv = 1'b1;
    for (int i = 0; i < n && i < int'(TR_MAX); i++) begin
      @(negedge clk);
      if (!hold) start_drv = 1'b0;
      tr_tx[i]   = m_tx;
      tr_busy[i] = m_busy;
      tr_done[i] = m_done;
      tr_addr[i] = m_addr;
    end
    start_drv = 1'b0;
  endtask

  // Expected trace: per word 2 fetch cycles high, then start, 8 data bits LSB first, stop
  task automatic check_dump(input string name, input int cpb, input int len, input bit hold);
    int   per;
    int   d;
    int   zeros_exp;
    int   zeros_obs;
    int   busy_obs;
    int   done_obs;
    logic eb;
    per       = 2 + 10 * cpb;
    d         = len * per;
    zeros_exp = 0;
    for (int w = 0; w < len; w++) begin
      int         base;
      int         err;
      logic [7:0] rx;
      logic [7:0] word;
      base = w * per;
      err  = 0;
      rx   = '0;
      word = mem[w];
      zeros_exp += cpb;
      for (int b = 0; b < 10; b++) begin
        if (b == 0)      eb = 1'b0;
        else if (b == 9) eb = 1'b1;
        else             eb = word[b-1];
        if (b > 0 && b < 9 && !eb) zeros_exp += cpb;
        for (int c = 0; c < cpb; c++)
          if (tr_tx[base + 2 + b * cpb + c] !== eb) err++;
      end
      for (int b = 0; b < 8; b++) rx[b] = tr_tx[base + 2 + (b + 1) * cpb + cpb / 2];
      check($sformatf("%s.w%0d.gap", name, w), 32'({tr_tx[base], tr_tx[base + 1]}), 32'h3);
      check($sformatf("%s.w%0d.frame_errs", name, w), 32'(err), 32'd0);
      check($sformatf("%s.w%0d.byte", name, w), 32'(rx), 32'(word));
      check($sformatf("%s.w%0d.addr", name, w), 32'(tr_addr[base + 2]), 32'(w));
    end
    zeros_obs = 0;
    busy_obs  = 0;
    done_obs  = 0;
    for (int i = 0; i <= d + 1; i++) begin
      if (!tr_tx[i])   zeros_obs++;
      if (tr_done[i])  done_obs++;
      if (i <= d && tr_busy[i]) busy_obs++;
    end
    check({name, ".tx_low_cycles"}, 32'(zeros_obs), 32'(zeros_exp));
    check({name, ".done_at_end"}, 32'(tr_done[d]), 32'd1);
    check({name, ".done_count"}, 32'(done_obs), 32'd1);
    check({name, ".busy_cycles"}, 32'(busy_obs), 32'(d));
    check({name, ".idle_busy"}, 32'(tr_busy[d + 1]), 32'd0);
    check({name, ".addr_after"}, 32'(tr_addr[d + 1]), 32'd0);
    if (len > 0) check({name, ".addr_last"}, 32'(tr_addr[d - 1]), 32'(len - 1));
    if (hold) check({name, ".restart_busy"}, 32'(tr_busy[d + 2]), 32'd1);
  endtask

  initial begin
    int done_seen;
    int low_seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    select_dut(0);
    check("rst.tx", 32'(m_tx), 32'd1);
    check("rst.busy", 32'(m_busy), 32'd0);
    check("rst.done", 32'(m_done), 32'd0);
    check("rst.addr", 32'(m_addr), 32'd0);

    // Basic dump, CLKS_PER_BIT=4, LEN=3
    mem[0] = 8'h55;
    mem[1] = 8'hA3;
    mem[2] = 8'h00;
    run_dump(3 * 42 + 2, 1'b0);
    check_dump("basic", 4, 3, 1'b0);

    // Reset while bit 3 of word 1 is on the line (trace index 60..63)
    @(negedge clk);
    run_dump(62, 1'b0);
    check("midrst.pre_tx", 32'(tr_tx[61]), 32'd0);
    check("midrst.pre_addr", 32'(tr_addr[61]), 32'd1);
    rst_drv = 1'b0;
    @(negedge clk);
    check("midrst.tx", 32'(m_tx), 32'd1);
    check("midrst.busy", 32'(m_busy), 32'd0);
    check("midrst.addr", 32'(m_addr), 32'd0);
    check("midrst.done", 32'(m_done), 32'd0);
    rst_drv   = 1'b1;
    done_seen = 0;
    low_seen  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_done) done_seen++;
      if (!m_tx)  low_seen++;
    end
    check("midrst.no_done", 32'(done_seen), 32'd0);
    check("midrst.tx_idle", 32'(low_seen), 32'd0);
    run_dump(3 * 42 + 2, 1'b0);
    check_dump("restream", 4, 3, 1'b0);

    // Capture latency: an early sample of word 1 would see word 0 (0xFF)
    select_dut(1);
    mem[0] = 8'hFF;
    mem[1] = 8'h3C;
    run_dump(2 * 42 + 2, 1'b0);
    check_dump("latency", 4, 2, 1'b0);

    // start held high through the whole dump and the DONE cycle
    @(negedge clk);
    run_dump(2 * 42 + 3, 1'b1);
    check_dump("held", 4, 2, 1'b1);

    // Full address range with CLKS_PER_BIT=1
    select_dut(2);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    run_dump(256 * 12 + 2, 1'b0);
    check_dump("full", 1, 256, 1'b0);

    // LEN=0: done the cycle after start, tx never leaves idle
    select_dut(3);
    run_dump(2, 1'b0);
    check_dump("len0", 4, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_uart_streamer.md
Name: result_uart_streamer

Overview:
- Reader end of the filter-output RAM. The filter pipeline writes results at addresses 0..LEN-1; this block reads them back.
- After a start pulse, reads each address in order and transmits the byte on a UART 8N1 line (LSB first). Gives a host-side dump of the filtered sequence, alongside the button-driven seven-segment browser.
- Sits between the output RAM's read port and the board TX pin, on the same single clock as the RAM.

Parameters:
- DATA_BITS, 8, width of one RAM word and of one UART frame payload.
- ADDR_BITS, 8, width of the RAM read address.
- LEN, 255, number of words streamed (addresses 0..LEN-1); equals the filter's NO_INPUT sample count.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- RD_LATENCY, 2, cycles from driving rd_addr to valid ram_q (registered address plus registered output).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-low reset; sampled on posedge clk.
- start  input  1  level-sampled; a high cycle while IDLE begins a dump.
- rd_addr  output  ADDR_BITS  RAM read address.
- ram_q  input  DATA_BITS  RAM read data, valid RD_LATENCY cycles after rd_addr.
- tx  output  1  UART line, idle high.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse after the stop bit of the last word.

Behaviour:
- Reset (rst=0 at posedge) forces, from the next cycle:
  - state IDLE; tx=1, busy=0, done=0, rd_addr=0;
  - baud counter, bit counter and latency counter = 0.
  - Reset mid-frame aborts immediately. No partial stop bit is emitted and tx returns high the cycle after reset.
- States: IDLE, FETCH, START, DATA, STOP, DONE.
- IDLE:
  - tx=1, busy=0. On start=1: rd_addr<=0, go to FETCH, busy<=1.
  - LEN=0: start goes directly to DONE.
- FETCH:
  - Hold rd_addr and count RD_LATENCY cycles.
  - On the final count, capture ram_q into an internal shift register, then go to START.
  - ram_q is never sampled earlier.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - If rd_addr == LEN-1, go to DONE. Otherwise rd_addr <= rd_addr+1 and go to FETCH.
- DONE:
  - done=1 for exactly one cycle, busy<=0, rd_addr<=0, then IDLE.
  - Same-cycle start is ignored.
- Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
- Inter-frame gap is exactly RD_LATENCY cycles of idle-high tx, spent in FETCH.
- start while busy=1 is ignored; no queuing.
- Address arithmetic is unsigned, ADDR_BITS wide. The LEN-1 terminal compare prevents wrap.
  - LEN = 2^ADDR_BITS is legal; the final address is all-ones.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and clears on every state change;
  - its width is $clog2(CLKS_PER_BIT) with a minimum of 1.
  - CLKS_PER_BIT=1 must work.
- tx is driven from a register and never glitches.
- rd_addr changes only on the FETCH-entry and DONE transitions.

Test Plan:
- Basic dump, CLKS_PER_BIT=4, LEN=3, RAM = {0x55, 0xA3, 0x00}, pulse start:
  - tx shows three 40-cycle frames with bits LSB first: 0x55 → 0,1,0,1,0,1,0,1,0,1; 0xA3 → 0,1,1,0,0,0,1,0,1,1.
  - Gaps of 2 high cycles between frames.
  - done pulses once; busy is high throughout.
- Latency check, RD_LATENCY=2, RAM model returns 0xFF until its 2nd cycle:
  - the transmitted byte equals the true word (0x3C), never 0xFF.
- start held high continuously through a LEN=2 dump:
  - exactly 2 frames, then one done pulse, then the dump restarts only from IDLE.
  - Confirm the done-cycle start is ignored and the next start is accepted the cycle after.
- Reset mid-DATA (bit 3 of the second word):
  - tx=1 next cycle, busy=0, rd_addr=0, no done pulse.
  - A fresh start restreams from address 0.
- Full range, LEN=256, ADDR_BITS=8, RAM[i]=i:
  - 256 frames carrying 0x00..0xFF in order.
  - rd_addr ends at 0xFF before DONE, then returns to 0 with no wrap frame.
- Edge parameters:
  - CLKS_PER_BIT=1: frames are 10 cycles each.
  - LEN=0: start yields done the cycle after, with tx constantly high.
